// File: rtl/ones_cnt_pkg.sv
// Shared definitions for the sequential ones counter: FSM state encoding and a
// width helper used to size counters from their maximum value.
package ones_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2_w(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ones_counter_seq_popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice of the word being counted.
module popcount_chunk
  import ones_cnt_pkg::*;
#(
  parameter int CHUNK = 4,
  localparam int PCW = clog2_w(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] in_bits,
  output logic [PCW-1:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + PCW'(in_bits[i]);
    end
  end

endmodule

// File: rtl/ones_counter_seq.sv
// Multicycle ones counter: counts CHUNK bits per clock with valid/ready on both sides
// and keeps a saturating running total. Define ONES_CNT_PARITY_EN to add out_parity.
module ones_counter_seq
  import ones_cnt_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CHUNK   = 4,
  parameter int TOTAL_W = 12,
  localparam int CW     = clog2_w(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_word,
  input  logic               acc_en,
  input  logic               clear_total,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      out_count,
  output logic [TOTAL_W-1:0] total,
  output logic               total_sat
`ifdef ONES_CNT_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  localparam int BEATS = WIDTH / CHUNK;
  localparam int BCW   = clog2_w(BEATS);
  localparam int PCW   = clog2_w(CHUNK + 1);
  localparam int SUM_W = ((CW > TOTAL_W) ? CW : TOTAL_W) + 1;
  localparam logic [SUM_W-1:0] TOTAL_MAX = {{(SUM_W - TOTAL_W){1'b0}}, {TOTAL_W{1'b1}}};

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("ones_counter_seq: CHUNK must be in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  state_e               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [CW-1:0]        out_count_q, out_count_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic                 total_sat_q, total_sat_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [CW-1:0]        psum_q, psum_d;
  logic [BCW-1:0]       beat_q, beat_d;
  logic                 acc_q, acc_d;
`ifdef ONES_CNT_PARITY_EN
  logic                 out_parity_q, out_parity_d;
`endif

  logic [PCW-1:0]       chunk_cnt;
  logic [CW-1:0]        beat_sum;
  logic [SUM_W-1:0]     sum_ext;

  popcount_chunk #(.CHUNK(CHUNK)) u_popcount (
    .in_bits (shift_q[CHUNK-1:0]),
    .count   (chunk_cnt)
  );

  assign beat_sum = psum_q + CW'(chunk_cnt);
  assign sum_ext  = {{(SUM_W - TOTAL_W){1'b0}}, total_q} + {{(SUM_W - CW){1'b0}}, out_count_q};

  // DONE spends one cycle raising out_valid, giving the WIDTH/CHUNK+1 accept-to-valid latency.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    total_d     = total_q;
    total_sat_d = total_sat_q;
    shift_d     = shift_q;
    psum_d      = psum_q;
    beat_d      = beat_q;
    acc_d       = acc_q;
`ifdef ONES_CNT_PARITY_EN
    out_parity_d = out_parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          shift_d    = in_word;
          acc_d      = acc_en;
          psum_d     = '0;
          beat_d     = BCW'(BEATS - 1);
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        shift_d = shift_q >> CHUNK;
        psum_d  = beat_sum;
        beat_d  = beat_q - BCW'(1);
        if (beat_q == '0) begin
          out_count_d = beat_sum;
`ifdef ONES_CNT_PARITY_EN
          // The parity of a word is the LSB of its ones count.
          out_parity_d = beat_sum[0];
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
          if (acc_q) begin
            if (sum_ext > TOTAL_MAX) begin
              total_d     = '1;
              total_sat_d = 1'b1;
            end else begin
              total_d = sum_ext[TOTAL_W-1:0];
            end
          end
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase

    if (clear_total) begin
      total_d     = '0;
      total_sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      total_q     <= '0;
      total_sat_q <= 1'b0;
      shift_q     <= '0;
      psum_q      <= '0;
      beat_q      <= '0;
      acc_q       <= 1'b0;
`ifdef ONES_CNT_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      total_q     <= total_d;
      total_sat_q <= total_sat_d;
      shift_q     <= shift_d;
      psum_q      <= psum_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
`ifdef ONES_CNT_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign total     = total_q;
  assign total_sat = total_sat_q;
`ifdef ONES_CNT_PARITY_EN
  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_ones_counter_seq.sv
// Scoreboard bench for ones_counter_seq: random and directed words against a
// popcount/saturating-sum reference, plus a CHUNK=16, TOTAL_W=6 instance.
module tb_ones_counter_seq;

  localparam int WIDTH   = 16;
  localparam int CHUNK   = 4;
  localparam int TOTAL_W = 12;
  localparam int LAT     = WIDTH / CHUNK + 1;
  localparam int TMAX    = (1 << TOTAL_W) - 1;
  localparam int B_TMAX  = (1 << 6) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_word = '0;
  logic              acc_en = 1'b0;
  logic              clear_total = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [4:0]        out_count;
  logic [TOTAL_W-1:0] total;
  logic              total_sat;

  logic              b_in_valid = 1'b0;
  logic              b_in_ready;
  logic [WIDTH-1:0]  b_in_word = '0;
  logic              b_acc_en = 1'b0;
  logic              b_clear_total = 1'b0;
  logic              b_out_valid;
  logic              b_out_ready = 1'b0;
  logic [4:0]        b_out_count;
  logic [5:0]        b_total;
  logic              b_total_sat;
`ifdef ONES_CNT_PARITY_EN
  logic              out_parity;
  logic              b_out_parity;
`endif

  typedef struct {
    int count;
    bit parity;
    bit acc;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   model_total = 0;
  bit   model_sat = 1'b0;
  bit   prev_valid = 1'b0;
  bit   hs_prev = 1'b0;

  always #5 clk = ~clk;

  ones_counter_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TOTAL_W(TOTAL_W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .acc_en      (acc_en),
    .clear_total (clear_total),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .total       (total),
    .total_sat   (total_sat)
`ifdef ONES_CNT_PARITY_EN
    ,
    .out_parity  (out_parity)
`endif
  );

  ones_counter_seq #(.WIDTH(WIDTH), .CHUNK(16), .TOTAL_W(6)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .in_word     (b_in_word),
    .acc_en      (b_acc_en),
    .clear_total (b_clear_total),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .out_count   (b_out_count),
    .total       (b_total),
    .total_sat   (b_total_sat)
`ifdef ONES_CNT_PARITY_EN
    ,
    .out_parity  (b_out_parity)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic failNote(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got nothing within the cycle budget, expected a response", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: compares whatever the DUT presents against the scoreboard head and the total model.
  always @(negedge clk) begin
    exp_t e;
    bit   hs;
    if (!rst_n) begin
      exp_q.delete();
      acc_cyc_q.delete();
      model_total = 0;
      model_sat   = 1'b0;
      prev_valid  = 1'b0;
      hs_prev     = 1'b0;
    end else begin
      checkOutput("valid_ready_exclusive", 32'(out_valid && in_ready), 32'd0);
      checkOutput("total", 32'(total), model_total);
      checkOutput("total_sat", 32'(total_sat), 32'(model_sat));
      if (hs_prev) checkOutput("in_ready_after_handshake", 32'(in_ready), 32'd1);
      if (in_valid && in_ready) acc_cyc_q.push_back(cycle + 1);
      hs = out_valid && out_ready;
      e  = '{count: 0, parity: 1'b0, acc: 1'b0};
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got out_valid with count %0d, expected no result", out_count);
        end else begin
          e = exp_q[0];
          checkOutput("out_count", 32'(out_count), e.count);
`ifdef ONES_CNT_PARITY_EN
          checkOutput("out_parity", 32'(out_parity), 32'(e.parity));
`endif
          if (!prev_valid) begin
            if (acc_cyc_q.size() == 0) failNote("latency_accept");
            else checkOutput("latency", cycle - acc_cyc_q.pop_front(), LAT);
          end
        end
      end
      if (clear_total) begin
        model_total = 0;
        model_sat   = 1'b0;
      end else if (hs && exp_q.size() > 0 && e.acc) begin
        if (model_total + e.count > TMAX) begin
          model_total = TMAX;
          model_sat   = 1'b1;
        end else begin
          model_total = model_total + e.count;
        end
      end
      if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
      prev_valid = out_valid;
      hs_prev    = hs;
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] word, input bit acc, input int hold, input bit clr);
    int n;
    exp_q.push_back('{count: $countones(word), parity: ^word, acc: acc});
    in_word  = word;
    acc_en   = acc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) failNote("accept_timeout");
    tick();
    in_valid  = 1'b0;
    in_word   = WIDTH'($urandom);
    acc_en    = 1'($urandom);
    out_ready = (hold == 0);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (n >= 50) failNote("valid_timeout");
    repeat (hold) begin out_ready = 1'b0; tick(); end
    out_ready   = 1'b1;
    clear_total = clr;
    tick();
    out_ready   = 1'b0;
    clear_total = 1'b0;
  endtask

  task automatic pulseClear();
    clear_total = 1'b1;
    tick();
    clear_total = 1'b0;
  endtask

  task automatic runB(input logic [WIDTH-1:0] word, input bit acc, output int lat, output int cnt, output bit par);
    b_in_word  = word;
    b_acc_en   = acc;
    b_in_valid = 1'b1;
    checkOutput("b_in_ready", 32'(b_in_ready), 32'd1);
    tick();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin tick(); lat++; end
    cnt = 32'(b_out_count);
`ifdef ONES_CNT_PARITY_EN
    par = b_out_parity;
`else
    par = ^word;
`endif
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, cnt;
    bit par;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_count", 32'(out_count), 32'd0);
    checkOutput("reset_total", 32'(total), 32'd0);

    applyStimulus(16'h0000, 1'b0, 0, 1'b0);
    applyStimulus(16'hFFFF, 1'b0, 0, 1'b0);
    applyStimulus(16'hA5A5, 1'b0, 3, 1'b0);

    pulseClear();
    applyStimulus(16'h00FF, 1'b1, 0, 1'b0);
    checkOutput("acc_first", 32'(total), 32'd8);
    applyStimulus(16'h00FF, 1'b1, 1, 1'b0);
    checkOutput("acc_second", 32'(total), 32'd16);
    applyStimulus(16'h00FF, 1'b1, 2, 1'b0);
    checkOutput("acc_third", 32'(total), 32'd24);
    applyStimulus(16'h00FF, 1'b1, 0, 1'b1);
    checkOutput("acc_clear_wins", 32'(total), 32'd0);

    repeat (255) applyStimulus(16'hFFFF, 1'b1, 0, 1'b0);
    checkOutput("sat_edge_total", 32'(total), 32'd4080);
    checkOutput("sat_edge_flag", 32'(total_sat), 32'd0);
    applyStimulus(16'hFFFF, 1'b1, 0, 1'b0);
    checkOutput("sat_total", 32'(total), TMAX);
    checkOutput("sat_flag", 32'(total_sat), 32'd1);
    applyStimulus(16'h0101, 1'b1, 0, 1'b0);
    checkOutput("sat_sticky", 32'(total_sat), 32'd1);
    pulseClear();
    checkOutput("sat_cleared_total", 32'(total), 32'd0);
    checkOutput("sat_cleared_flag", 32'(total_sat), 32'd0);

    repeat (60) begin
      if ($urandom_range(0, 7) == 0) pulseClear();
      applyStimulus(WIDTH'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    $urandom_range(0, 5) == 0);
    end

    pulseClear();
    applyStimulus(16'hFFFF, 1'b1, 0, 1'b0);
    checkOutput("pre_reset_total", 32'(total), 32'd16);
    in_word  = 16'h1234;
    acc_en   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_total", 32'(total), 32'd0);
    checkOutput("async_reset_total_sat", 32'(total_sat), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h8001, 1'b0, 0, 1'b0);

    runB(16'h8001, 1'b0, lat, cnt, par);
    checkOutput("b_latency", lat, 32'd2);
    checkOutput("b_count_8001", cnt, 32'd2);
    runB(16'h0007, 1'b0, lat, cnt, par);
    checkOutput("b_count_0007", cnt, 32'd3);
`ifdef ONES_CNT_PARITY_EN
    checkOutput("b_parity_0007", 32'(par), 32'd1);
`endif
    for (int i = 1; i <= 4; i++) begin
      runB(16'hFFFF, 1'b1, lat, cnt, par);
      checkOutput("b_sat_total", 32'(b_total), (16 * i > B_TMAX) ? B_TMAX : 16 * i);
      checkOutput("b_sat_flag", 32'(b_total_sat), 32'(i == 4));
    end
    b_clear_total = 1'b1;
    tick();
    b_clear_total = 1'b0;
    checkOutput("b_clear_total", 32'(b_total), 32'd0);
    checkOutput("b_clear_flag", 32'(b_total_sat), 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
